// File: rtl/mem_bist.sv
// mem_bist: four-phase march BIST (write A up, verify A up, write ~A down, verify ~A down).
// First-failure capture of fail_addr/fail_data is built only when MEM_BIST_FAIL_LOG_EN is defined.
module mem_bist #(
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);
  localparam int unsigned STEP_WIDTH = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [STEP_WIDTH-1:0] LAST_WR = STEP_WIDTH'(DEPTH - 1);
  localparam logic [STEP_WIDTH-1:0] LAST_RD = STEP_WIDTH'(DEPTH + READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR_A, RD_A, WR_B, RD_B, DONE} state_t;

  state_t                  state, state_nxt;
  logic [STEP_WIDTH-1:0]   step, step_nxt;
  logic [ADDR_WIDTH-1:0]   addr_c;
  logic [DATA_WIDTH-1:0]   data_c;
  logic                    wren_c, issue_c, invert_c;
  logic                    rd_issue;
  logic                    start_run_c, finish_c, mismatch_c;
  logic [READ_LATENCY-1:0] pipe_valid;
  logic [DATA_WIDTH-1:0]   pipe_exp [READ_LATENCY];

  // Address bits replicated from bit 0 upward, truncated at the top.
  function automatic logic [DATA_WIDTH-1:0] pattern_a(input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH; i++) p[i] = a[i % ADDR_WIDTH];
    return p;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step + STEP_WIDTH'(1);
    case (state)
      IDLE, DONE: begin
        step_nxt = '0;
        if (start) state_nxt = WR_A;
      end
      WR_A: if (step == LAST_WR) begin state_nxt = RD_A; step_nxt = '0; end
      RD_A: if (step == LAST_RD) begin state_nxt = WR_B; step_nxt = '0; end
      WR_B: if (step == LAST_WR) begin state_nxt = RD_B; step_nxt = '0; end
      RD_B: if (step == LAST_RD) begin state_nxt = DONE; step_nxt = '0; end
      default: begin state_nxt = IDLE; step_nxt = '0; end
    endcase
  end

  // Memory-side controls for the upcoming cycle; descending phases use the complemented step.
  always_comb begin
    addr_c   = step_nxt[ADDR_WIDTH-1:0];
    wren_c   = 1'b0;
    issue_c  = 1'b0;
    invert_c = 1'b0;
    case (state_nxt)
      WR_A: wren_c = 1'b1;
      RD_A: issue_c = (step_nxt[STEP_WIDTH-1:ADDR_WIDTH] == '0);
      WR_B: begin
        wren_c   = 1'b1;
        invert_c = 1'b1;
        addr_c   = ~step_nxt[ADDR_WIDTH-1:0];
      end
      RD_B: begin
        issue_c  = (step_nxt[STEP_WIDTH-1:ADDR_WIDTH] == '0);
        invert_c = 1'b1;
        addr_c   = ~step_nxt[ADDR_WIDTH-1:0];
      end
      default: ;
    endcase
    data_c = pattern_a(addr_c) ^ {DATA_WIDTH{invert_c}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
      rd_issue    <= 1'b0;
    end else begin
      mem_address <= addr_c;
      mem_data    <= data_c;
      mem_wren    <= wren_c;
      rd_issue    <= issue_c;
    end
  end

  // Read pipe: mem_data holds the expected word while a read is presented.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
    end
  end

  always_ff @(posedge clock) begin
    pipe_exp[0] <= mem_data;
    for (int i = 1; i < READ_LATENCY; i++) pipe_exp[i] <= pipe_exp[i-1];
  end

  assign start_run_c = ((state == IDLE) || (state == DONE)) && start;
  assign finish_c    = (state == RD_B) && (state_nxt == DONE);
  assign mismatch_c  = pipe_valid[READ_LATENCY-1] && (mem_q != pipe_exp[READ_LATENCY-1]);

  always_ff @(posedge clock) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else if (start_run_c) begin
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
    end else begin
      if (mismatch_c && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
      if (finish_c) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_count == 16'd0) && !mismatch_c;
      end
    end
  end

`ifdef MEM_BIST_FAIL_LOG_EN
  logic                  fail_seen;
  logic [ADDR_WIDTH-1:0] pipe_addr [READ_LATENCY];

  always_ff @(posedge clock) begin
    pipe_addr[0] <= mem_address;
    for (int i = 1; i < READ_LATENCY; i++) pipe_addr[i] <= pipe_addr[i-1];
  end

  always_ff @(posedge clock) begin
    if (reset || start_run_c) begin
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (mismatch_c && !fail_seen) begin
      fail_seen <= 1'b1;
      fail_addr <= pipe_addr[READ_LATENCY-1];
      fail_data <= mem_q;
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist (ADDR_WIDTH=4, DATA_WIDTH=8, READ_LATENCY=1) with a fault-injecting memory model.
// Capture expectations follow MEM_BIST_FAIL_LOG_EN as seen by this file.
module tb_mem_bist;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done, pass, mem_wren;
  logic [15:0] err_count;
  logic [3:0]  fail_addr, mem_address;
  logic [7:0]  fail_data, mem_data, mem_q;

  int errors = 0;
  int checks = 0;
  int fault_mode = 0;  // 0 clean, 1 addr 5 bit 0 stuck low, 2 addr bit 3 ignored
  logic [7:0]  mem_arr [16];
  logic [11:0] wlog [$];

  mem_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] eff_addr(input logic [3:0] a);
    return (fault_mode == 2) ? {1'b0, a[2:0]} : a;
  endfunction

  always @(posedge clock) begin
    if (mem_wren) begin
      mem_arr[eff_addr(mem_address)] <= mem_data;
      wlog.push_back({mem_address, mem_data});
    end
    if (fault_mode == 1 && mem_address == 4'd5) mem_q <= mem_arr[eff_addr(mem_address)] & 8'hFE;
    else mem_q <= mem_arr[eff_addr(mem_address)];
  end

  // Pulses start (sampled at edge 0) and samples #1 after each later edge until done or stop_at.
  task automatic run_bist(input int pulse_at, input int stop_at, output int cycles, output int busy_n);
    cycles = -1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    busy_n = busy ? 1 : 0;
    for (int n = 1; n <= 300; n++) begin
      start = (n == pulse_at);
      @(posedge clock); #1;
      start = 1'b0;
      if (busy) busy_n++;
      if (done || n == stop_at) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b want 0", pass); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %0b want 0", mem_wren); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL reset_err: got %0h want 0", err_count); end
    checks++; if (fail_addr !== 4'h0) begin errors++; $display("FAIL reset_faddr: got %0h want 0", fail_addr); end
    checks++; if (fail_data !== 8'h0) begin errors++; $display("FAIL reset_fdata: got %0h want 0", fail_data); end
    checks++; if (mem_address !== 4'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_address); end
    checks++; if (mem_data !== 8'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", mem_data); end
  endtask

  task automatic test_fault_free();
    int cyc, bsy;
    fault_mode = 0;
    wlog.delete();
    run_bist(0, 0, cyc, bsy);
    checks++; if (cyc !== 66) begin errors++; $display("FAIL clean_done_cycle: got %0d want 66", cyc); end
    checks++; if (bsy !== 66) begin errors++; $display("FAIL clean_busy_cycles: got %0d want 66", bsy); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clean_busy_end: got %0b want 0", busy); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL clean_pass: got %0b want 1", pass); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL clean_err: got %0h want 0", err_count); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL clean_wren_done: got %0b want 0", mem_wren); end
    checks++; if (wlog.size() !== 32) begin errors++; $display("FAIL clean_write_count: got %0d want 32", wlog.size()); end
    for (int i = 0; i < 32 && i < wlog.size(); i++) begin
      logic [3:0]  a;
      logic [11:0] want;
      if (i < 16) begin
        a = 4'(i);
        want = {a, a, a};
      end else begin
        a = 4'(31 - i);
        want = {a, ~{a, a}};
      end
      checks++;
      if (wlog[i] !== want) begin
        errors++;
        $display("FAIL clean_write[%0d]: got addr %0h data %0h want addr %0h data %0h",
                 i, wlog[i][11:8], wlog[i][7:0], want[11:8], want[7:0]);
      end
    end
  endtask

  task automatic test_stuck_bit();
    int cyc, bsy;
    logic [3:0] want_a;
    logic [7:0] want_d;
`ifdef MEM_BIST_FAIL_LOG_EN
    want_a = 4'd5;
    want_d = 8'h54;
`else
    want_a = 4'd0;
    want_d = 8'h00;
`endif
    fault_mode = 1;
    run_bist(0, 0, cyc, bsy);
    checks++; if (cyc !== 66) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 66", cyc); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL stuck_err: got %0d want 1", err_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL stuck_pass: got %0b want 0", pass); end
    checks++; if (fail_addr !== want_a) begin errors++; $display("FAIL stuck_faddr: got %0h want %0h", fail_addr, want_a); end
    checks++; if (fail_data !== want_d) begin errors++; $display("FAIL stuck_fdata: got %0h want %0h", fail_data, want_d); end
  endtask

  task automatic test_alias();
    int cyc, bsy;
    logic [3:0] want_a;
    logic [7:0] want_d;
`ifdef MEM_BIST_FAIL_LOG_EN
    want_a = 4'd0;
    want_d = 8'h88;
`else
    want_a = 4'd0;
    want_d = 8'h00;
`endif
    fault_mode = 2;
    run_bist(0, 0, cyc, bsy);
    checks++; if (cyc !== 66) begin errors++; $display("FAIL alias_done_cycle: got %0d want 66", cyc); end
    checks++; if (err_count !== 16'd16) begin errors++; $display("FAIL alias_err: got %0d want 16", err_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL alias_pass: got %0b want 0", pass); end
    checks++; if (fail_addr !== want_a) begin errors++; $display("FAIL alias_faddr: got %0h want %0h", fail_addr, want_a); end
    checks++; if (fail_data !== want_d) begin errors++; $display("FAIL alias_fdata: got %0h want %0h", fail_data, want_d); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bsy;
    fault_mode = 1;
    run_bist(0, 30, cyc, bsy);
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL midrst_err_before: got %0d want 1", err_count); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b want 0", done); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL midrst_err: got %0h want 0", err_count); end
    checks++; if (mem_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren: got %0b want 0", mem_wren); end
    repeat (3) @(posedge clock);
    #1;
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL midrst_err_quiet: got %0h want 0", err_count); end
    fault_mode = 0;
    run_bist(0, 0, cyc, bsy);
    checks++; if (cyc !== 66) begin errors++; $display("FAIL midrst_rerun_cycle: got %0d want 66", cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL midrst_rerun_pass: got %0b want 1", pass); end
  endtask

  task automatic test_start_while_busy();
    int cyc, bsy;
    fault_mode = 0;
    run_bist(10, 0, cyc, bsy);
    checks++; if (cyc !== 66) begin errors++; $display("FAIL repulse_done_cycle: got %0d want 66", cyc); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL repulse_pass: got %0b want 1", pass); end
    @(posedge clock); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL repulse_no_restart: got busy %0b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    fault_mode = 1;
    start = 1'b1;
    @(posedge clock); #1;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checks++; if (n !== 66) begin errors++; $display("FAIL b2b_first_done: got %0d want 66", n); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL b2b_first_err: got %0d want 1", err_count); end
    @(posedge clock); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_restart_done: got %0b want 0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart_busy: got %0b want 1", busy); end
    checks++; if (err_count !== 16'h0) begin errors++; $display("FAIL b2b_restart_err: got %0h want 0", err_count); end
    start = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checks++; if (n !== 66) begin errors++; $display("FAIL b2b_second_done: got %0d want 66", n); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL b2b_second_err: got %0d want 1", err_count); end
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_bit();
    test_alias();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
